// File: rtl/fetch_address_unit.sv
// Fetch address unit: owns the fetch PC, issues in-order instruction fetches,
// buffers their responses and presents {pc, insn} to decode. A flush
// redirects the PC and marks every in-flight fetch for discard.
module fetch_address_unit #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] next_pc,
   input  logic        if_stall,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   input  logic        mem_req_ready,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_insn
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   logic [31:0]      pc_q, pc_d;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W-1:0] fill_q, fill_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic [CNT_W-1:0] infl_q, infl_d;
   logic [CNT_W-1:0] disc_q, disc_d;

   logic [31:0]      slot_pc_q   [DEPTH];
   logic [31:0]      slot_insn_q [DEPTH];
   logic [DEPTH-1:0] slot_filled_q;

   logic [SUM_W-1:0] used_c;
   logic             push_c;
   logic             pop_c;
   logic             resp_fill_c;
   logic             resp_drop_c;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Issue / present: slots held by live fetches plus pending discards bound issue
   always_comb begin
      used_c        = SUM_W'(occ_q) + SUM_W'(disc_q);
      mem_req_valid = !rst && !flush && (used_c < SUM_W'(DEPTH));
      mem_req_addr  = pc_q;
      out_valid     = slot_filled_q[head_q] && !rst && !flush;
      out_pc        = slot_pc_q[head_q];
      out_insn      = slot_insn_q[head_q];
      push_c        = mem_req_valid && mem_req_ready;
      pop_c         = out_valid && !if_stall;
      resp_drop_c   = mem_resp_valid && !flush && (disc_q != '0);
      resp_fill_c   = mem_resp_valid && !flush && (disc_q == '0) && (infl_q != '0);
   end

   // Next-state for PC, pointers and counters; flush overrides everything else
   always_comb begin
      pc_d   = pc_q;
      head_d = head_q;
      tail_d = tail_q;
      fill_d = fill_q;
      occ_d  = occ_q;
      infl_d = infl_q;
      disc_d = disc_q;
      if (flush) begin
         pc_d   = next_pc;
         head_d = '0;
         tail_d = '0;
         fill_d = '0;
         occ_d  = '0;
         infl_d = '0;
         // every unfilled slot becomes a discard, minus a response landing now
         disc_d = disc_q + infl_q - CNT_W'(mem_resp_valid);
      end else begin
         if (push_c) begin
            pc_d   = pc_q + 32'd4;
            tail_d = next_ptr(tail_q);
         end
         if (resp_fill_c) fill_d = next_ptr(fill_q);
         if (resp_drop_c) disc_d = disc_q - CNT_W'(1);
         if (pop_c)       head_d = next_ptr(head_q);
         occ_d  = occ_q + CNT_W'(push_c) - CNT_W'(pop_c);
         infl_d = infl_q + CNT_W'(push_c) - CNT_W'(resp_fill_c);
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         head_q <= '0;
         tail_q <= '0;
         fill_q <= '0;
         occ_q  <= '0;
         infl_q <= '0;
         disc_q <= '0;
      end else begin
         pc_q   <= pc_d;
         head_q <= head_d;
         tail_q <= tail_d;
         fill_q <= fill_d;
         occ_q  <= occ_d;
         infl_q <= infl_d;
         disc_q <= disc_d;
      end
   end

   // Filled flags: set by an accepted response, cleared on pop, flush or reset
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         slot_filled_q <= '0;
      end else begin
         if (pop_c)       slot_filled_q[head_q] <= 1'b0;
         if (resp_fill_c) slot_filled_q[fill_q] <= 1'b1;
      end
   end

   // Slot payloads: PC captured at issue, instruction captured at fill
   always_ff @(posedge clk) begin
      if (push_c)      slot_pc_q[tail_q]   <= pc_q;
      if (resp_fill_c) slot_insn_q[fill_q] <= mem_resp_data;
   end

   a_resp_outstanding: assert property (@(posedge clk) disable iff (rst)
      mem_resp_valid |-> ((disc_q != '0) || (infl_q != '0)))
      else $error("response with no outstanding fetch");

   a_disc_bound: assert property (@(posedge clk) disable iff (rst)
      disc_q <= CNT_W'(DEPTH))
      else $error("discard count exceeds depth");

endmodule

// File: tb/tb_fetch_address_unit.sv
// Bench for fetch_address_unit: directed vector table, then random traffic
// against a queue-based reference model with an in-order memory model.
module tb_fetch_address_unit;

   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] next_pc = '0;
   logic        if_stall = 1'b0;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready = 1'b1;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = '0;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_insn;

   always #5 clk = ~clk;

   fetch_address_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .next_pc        (next_pc),
      .if_stall       (if_stall),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .out_valid      (out_valid),
      .out_pc         (out_pc),
      .out_insn       (out_insn)
   );

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
   endtask

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // Reference model: queue of buffered fetches plus a discard count
   typedef struct { logic [31:0] pc; logic [31:0] insn; bit filled; } ent_t;
   ent_t        mq[$];
   logic [31:0] m_pc = RESET_PC;
   int          m_disc = 0;
   logic [31:0] memq[$];      // addresses accepted by memory, not yet answered
   bit          e_rv, e_ov;
   logic [31:0] e_addr, e_pc, e_insn;

   // Drive one cycle's inputs at negedge, then derive the model's expected outputs
   task automatic drive(input logic r, input logic f, input logic [31:0] npc,
                        input logic st, input logic rd, input logic hold);
      @(negedge clk);
      rst            = r;
      flush          = f;
      next_pc        = npc;
      if_stall       = st;
      mem_req_ready  = rd;
      mem_resp_valid = !r && !hold && (memq.size() > 0);
      mem_resp_data  = mem_resp_valid ? mdata(memq[0]) : $urandom;
      #1;
      e_rv   = !r && !f && ((mq.size() + m_disc) < DEPTH);
      e_addr = m_pc;
      e_ov   = !r && !f && (mq.size() > 0) && mq[0].filled;
      e_pc   = (mq.size() > 0) ? mq[0].pc : '0;
      e_insn = (mq.size() > 0) ? mq[0].insn : '0;
   endtask

   // Apply the clock edge to the model using the inputs driven this cycle
   task automatic advance();
      bit resp;
      int unfilled;
      @(posedge clk);
      resp = mem_resp_valid;
      if (rst) begin
         m_pc = RESET_PC;
         mq.delete();
         memq.delete();
         m_disc = 0;
      end else begin
         if (resp) void'(memq.pop_front());
         if (flush) begin
            unfilled = 0;
            foreach (mq[i]) if (!mq[i].filled) unfilled++;
            m_disc = m_disc + unfilled - (resp ? 1 : 0);
            mq.delete();
            m_pc = next_pc;
         end else begin
            if (resp) begin
               if (m_disc > 0) m_disc--;
               else begin
                  for (int i = 0; i < mq.size(); i++) begin
                     if (!mq[i].filled) begin
                        mq[i].filled = 1'b1;
                        mq[i].insn   = mem_resp_data;
                        break;
                     end
                  end
               end
            end
            if (e_ov && !if_stall) void'(mq.pop_front());
            if (e_rv && mem_req_ready) begin
               mq.push_back('{pc: m_pc, insn: 32'h0, filled: 1'b0});
               memq.push_back(m_pc);
               m_pc = m_pc + 32'd4;
            end
         end
      end
   endtask

   typedef struct {
      logic        r, f;
      logic [31:0] npc;
      logic        st, rd, hold;
      logic        erv;
      logic [31:0] eaddr;
      logic        eov;
      logic [31:0] epc;
   } vec_t;
   vec_t tbl[$];

   task automatic v(input logic r, input logic f, input logic [31:0] npc,
                    input logic st, input logic rd, input logic hold,
                    input logic erv, input logic [31:0] eaddr,
                    input logic eov, input logic [31:0] epc);
      tbl.push_back('{r: r, f: f, npc: npc, st: st, rd: rd, hold: hold,
                      erv: erv, eaddr: eaddr, eov: eov, epc: epc});
   endtask

   initial begin
      //  rst flush next_pc       stall rdy hold  rv  addr          ov  pc
      v(1, 0, 32'h0,           0, 1, 0,  0, 32'h0,           0, 32'h0);          // reset
      v(0, 0, 32'h0,           0, 1, 0,  1, 32'h8000_0000,   0, 32'h0);
      v(0, 0, 32'h0,           0, 1, 0,  1, 32'h8000_0004,   0, 32'h0);
      v(0, 0, 32'h0,           0, 1, 0,  0, 32'h0,           1, 32'h8000_0000);  // full
      v(0, 0, 32'h0,           0, 1, 0,  1, 32'h8000_0008,   1, 32'h8000_0004);
      v(0, 0, 32'h0,           0, 1, 0,  1, 32'h8000_000C,   0, 32'h0);
      for (int i = 0; i < 5; i++)                                                // stall x5
         v(0, 0, 32'h0,        1, 1, 0,  0, 32'h0,           1, 32'h8000_0008);
      v(0, 0, 32'h0,           0, 1, 0,  0, 32'h0,           1, 32'h8000_0008);
      v(0, 0, 32'h0,           0, 1, 0,  1, 32'h8000_0010,   1, 32'h8000_000C);
      v(0, 0, 32'h0,           0, 1, 0,  1, 32'h8000_0014,   0, 32'h0);
      v(0, 1, 32'hFFFF_FFFC,   0, 1, 0,  0, 32'h0,           0, 32'h0);          // flush + resp
      v(0, 0, 32'h0,           0, 1, 0,  1, 32'hFFFF_FFFC,   0, 32'h0);
      v(0, 0, 32'h0,           0, 1, 1,  1, 32'h0000_0000,   0, 32'h0);          // wrap
      v(0, 1, 32'h0000_1000,   0, 1, 1,  0, 32'h0,           0, 32'h0);          // 2 in flight
      v(0, 0, 32'h0,           0, 1, 0,  0, 32'h0,           0, 32'h0);          // dropped
      v(0, 0, 32'h0,           0, 1, 0,  1, 32'h0000_1000,   0, 32'h0);          // dropped
      v(0, 0, 32'h0,           0, 1, 0,  1, 32'h0000_1004,   0, 32'h0);
      v(0, 0, 32'h0,           0, 1, 0,  0, 32'h0,           1, 32'h0000_1000);
      v(0, 0, 32'h0,           0, 0, 0,  1, 32'h0000_1008,   1, 32'h0000_1004);  // ready low
      v(0, 0, 32'h0,           0, 0, 0,  1, 32'h0000_1008,   0, 32'h0);
      v(0, 0, 32'h0,           0, 0, 0,  1, 32'h0000_1008,   0, 32'h0);
      v(1, 0, 32'h0,           0, 0, 0,  0, 32'h0,           0, 32'h0);          // reset mid-stall
      v(0, 0, 32'h0,           0, 1, 0,  1, 32'h8000_0000,   0, 32'h0);
      v(0, 0, 32'h0,           0, 1, 0,  1, 32'h8000_0004,   0, 32'h0);
      v(0, 0, 32'h0,           0, 1, 0,  0, 32'h0,           1, 32'h8000_0000);

      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].f, tbl[i].npc, tbl[i].st, tbl[i].rd, tbl[i].hold);
         check($sformatf("vec%0d req_valid", i), 32'(mem_req_valid), 32'(tbl[i].erv));
         if (tbl[i].erv) check($sformatf("vec%0d req_addr", i), mem_req_addr, tbl[i].eaddr);
         check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
         if (tbl[i].eov) begin
            check($sformatf("vec%0d out_pc", i), out_pc, tbl[i].epc);
            check($sformatf("vec%0d out_insn", i), out_insn, mdata(tbl[i].epc));
         end
         advance();
      end

      // Random traffic against the reference model
      drive(1, 0, 32'h0, 0, 1, 0);
      advance();
      for (int c = 0; c < 3000; c++) begin
         logic        r, f, st, rd, hold;
         logic [31:0] npc;
         r    = ($urandom_range(199) == 0);
         f    = ($urandom_range(9) == 0);
         npc  = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         st   = ($urandom_range(2) == 0);
         rd   = ($urandom_range(3) != 0);
         hold = ($urandom_range(2) == 0);
         drive(r, f, npc, st, rd, hold);
         check("rnd req_valid", 32'(mem_req_valid), 32'(e_rv));
         if (e_rv) check("rnd req_addr", mem_req_addr, e_addr);
         check("rnd out_valid", 32'(out_valid), 32'(e_ov));
         if (e_ov) begin
            check("rnd out_pc", out_pc, e_pc);
            check("rnd out_insn", out_insn, e_insn);
         end
         advance();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
